// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage.
//   IF_ADDR_W / IF_DATA_W : default address and instruction widths
//   IF_RESET_PC           : default PC loaded on reset
//   IF_PC_INC             : sequential fetch stride in bytes
//   fetch_entry_t         : {pc, instr, exc} layout of one prefetch-queue entry
//                           at the default widths
package if_pkg;

  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_DATA_W   = 32;
  localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
  localparam int unsigned IF_PC_INC   = 4;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
    logic                 exc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO used for the prefetch queue and for the in-flight PC list.
// The head entry is read straight out of the storage registers, so it is
// valid in the cycle after it was pushed.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   flush_i   : empty the FIFO (wins over push/pop)
//   push_i    : write wdata_i at the tail
//   wdata_i   : tail data
//   pop_i     : retire the head entry
//   count_o   : number of valid entries (0..DEPTH)
//   head_o    : head entry (all-zero after reset)
module if_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue and multiple outstanding
// in-order memory requests. A redirect flushes the queue and every in-flight
// fetch, then restarts fetching at redirect_pc.
// Optional build macro: IF_ADDR_EXC_EN -- a misaligned PC produces a single
// exception entry (out_exc=1) instead of a memory request and halts fetch
// until the next redirect. Without it out_exc is always 0.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc  : flush and restart fetch at redirect_pc
//   imem_req, imem_addr          : request to instruction memory (addr = pc)
//   imem_gnt                     : request accepted when imem_req && imem_gnt
//   imem_rvalid, imem_rdata      : in-order response
//   out_valid, out_ready         : handshake to decode
//   out_pc, out_instr, out_exc   : queue head
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_exc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              exc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     q_count, if_count;
  logic [ADDR_W-1:0] if_head;
  entry_t            q_wdata, q_head;
  logic              acc, rsp_drop, rsp_push, q_push, q_pop;
  logic              exc_push, fetch_ok;
  logic [SW-1:0]     used;

  assign acc      = imem_req && imem_gnt;
  // Responses are discarded while older requests are still owed, or when a
  // redirect arrives in the same cycle.
  assign rsp_drop = imem_rvalid && (redirect_valid || (drop_q != '0));
  assign rsp_push = imem_rvalid && !rsp_drop;

  // Credit: queued entries plus every outstanding request (live or to be
  // dropped) may never exceed DEPTH, so the queue can never overflow.
  assign used     = SW'(q_count) + SW'(if_count) + SW'(drop_q);
  assign imem_req = !rst && !redirect_valid && fetch_ok && (used < SW'(DEPTH));
  assign imem_addr = pc_q;

`ifdef IF_ADDR_EXC_EN
  logic halt_q, halt_d, misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);
  // Wait for all live responses so the exception entry stays in program order.
  assign exc_push   = !redirect_valid && misaligned && !halt_q &&
                      (if_count == '0) && (q_count != CW'(DEPTH));
  assign fetch_ok   = !misaligned && !halt_q;

  always_comb begin
    halt_d = halt_q;
    if (redirect_valid)  halt_d = 1'b0;
    else if (exc_push)   halt_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`else
  assign exc_push = 1'b0;
  assign fetch_ok = 1'b1;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (acc)       pc_d = pc_q + ADDR_W'(IF_PC_INC);
  end

  // Every request not yet answered becomes a drop on redirect; a response
  // arriving in the redirect cycle consumes one of them.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid)
      drop_d = CW'(SW'(drop_q) + SW'(if_count) + SW'(acc) - SW'(imem_rvalid));
    else if (imem_rvalid && (drop_q != '0))
      drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  if_fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (acc),
    .wdata_i (pc_q),
    .pop_i   (rsp_push),
    .count_o (if_count),
    .head_o  (if_head)
  );

  always_comb begin
    q_wdata.pc    = if_head;
    q_wdata.instr = imem_rdata;
    q_wdata.exc   = 1'b0;
    if (exc_push) begin
      q_wdata.pc    = pc_q;
      q_wdata.instr = '0;
      q_wdata.exc   = 1'b1;
    end
  end

  assign q_push = rsp_push || exc_push;
  assign q_pop  = out_valid && out_ready && !redirect_valid;

  if_fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .count_o (q_count),
    .head_o  (q_head)
  );

  assign out_valid = (q_count != '0);
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;
  assign out_exc   = q_head.exc;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: directed stimulus pushes hand-computed
// {pc, instr, exc} entries into exp_q; a monitor pops and compares on every
// decode handshake. The memory model returns the request address as data.
module tb_if_prefetch_stage;
  import if_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic              out_exc;

  if_prefetch_stage #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_exc        (out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int           checks    = 0;
  int           failures  = 0;
  int           cyc       = 0;
  int           mem_lat   = 1;
  int           grant_cnt = 0;
  bit           hold_ready = 1'b1;
  fetch_entry_t exp_q[$];
  pend_t        pend_q[$];
  int           pop_cyc[$];
  fetch_entry_t got, want;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model + decode ready driver. Inputs change at negedge, requests
  // are sampled 3 time units later, well before the next rising edge.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    out_ready   = 1'b0;
    forever begin
      @(negedge clk);
      imem_gnt  = 1'b1;
      out_ready = !hold_ready && (exp_q.size() != 0);
      if (rst) begin
        pend_q.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end else if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_q[0].addr;
        void'(pend_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      #3;
      if (!rst && imem_req && imem_gnt) begin
        pend_q.push_back('{imem_addr, cyc + mem_lat});
        grant_cnt++;
      end
    end
  end

  // Monitor: compare every accepted head entry against the scoreboard.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      got.pc    = out_pc;
      got.instr = out_instr;
      got.exc   = out_exc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry got pc=%h instr=%h exc=%b (nothing expected)",
                 got.pc, got.instr, got.exc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL entry got pc=%h instr=%h exc=%b want pc=%h instr=%h exc=%b",
                   got.pc, got.instr, got.exc, want.pc, want.instr, want.exc);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push_one(logic [31:0] pc, logic [31:0] instr, logic exc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.exc   = exc;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(logic [31:0] base, int n);
    for (int i = 0; i < n; i++) push_one(base + 32'(4 * i), base + 32'(4 * i), 1'b0);
  endtask

  task automatic wait_drain(string name, int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d entries outstanding want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asserts reset away from any clock edge (checks outputs respond without a
  // clock) and releases it 1 unit after a negedge; returns in the release cycle.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req",  32'(imem_req),  32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_instr", out_instr,      32'd0);
    chk("rst_out_exc",   32'(out_exc),   32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_redirect(logic [31:0] addr);
    @(negedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    hold_ready     = 1'b0;
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  int first;
  int n;
  int req_seen;

  initial begin
    // 1: reset fetch, 1 instr/cycle, first valid 2 edges after release
    mem_lat    = 1;
    hold_ready = 1'b0;
    push_seq(32'hBFC0_0000, 3);
    pop_cyc.delete();
    do_reset();
    first = -1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (out_valid && first < 0) first = i;
    end
    chk("first_valid_latency", 32'(first), 32'd2);
    wait_drain("reset_seq", 20);
    chk("reset_seq_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() >= 3)
      chk("back_to_back_pops", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);

    // 2: decode stalled -> exactly DEPTH grants, then resume at base+0x10
    hold_ready = 1'b1;
    grant_cnt  = 0;
    do_reset();
    repeat (20) @(negedge clk);
    #1;
    chk("grants_while_stalled", 32'(grant_cnt), 32'd4);
    chk("req_low_when_full",    32'(imem_req),  32'd0);
    chk("valid_when_full",      32'(out_valid), 32'd1);
    push_seq(32'hBFC0_0000, 8);
    hold_ready = 1'b0;
    wait_drain("stall_release", 40);

    // 3: 3-cycle memory, redirect with 3 requests in flight
    hold_ready = 1'b1;
    mem_lat    = 3;
    grant_cnt  = 0;
    do_reset();
    n = 0;
    while (grant_cnt < 3 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("inflight_before_redirect", 32'(grant_cnt), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    push_seq(32'h0040_0000, 2);
    hold_ready = 1'b0;
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_drain("redirect_lat3", 40);
    chk("drop_cnt_idle_lat3", 32'(dut.drop_q), 32'd0);

    // 4: redirect coincident with a grant and a response at pc 0x100
    mem_lat    = 1;
    hold_ready = 1'b1;
    do_reset();
    do_redirect(32'h0000_00F8);
    hold_ready = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h100) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_pc_100",      imem_addr,          32'h100);
    chk("coincident_rvalid", 32'(imem_rvalid),   32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    push_seq(32'h0000_0200, 3);
    hold_ready = 1'b0;
    #1;
    chk("req_low_on_redirect", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
    #1;
    chk("req_after_redirect",  32'(imem_req), 32'd1);
    chk("addr_after_redirect", imem_addr,     32'h200);
    @(negedge clk);
    #1;
    chk("valid_redirect_n2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("valid_redirect_n3", 32'(out_valid), 32'd1);
    wait_drain("coincident", 30);
    chk("drop_cnt_idle", 32'(dut.drop_q), 32'd0);

    // 5: PC wrap
    do_redirect(32'hFFFF_FFF8);
    push_one(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
    push_one(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    push_one(32'h0000_0000, 32'h0000_0000, 1'b0);
    push_one(32'h0000_0004, 32'h0000_0004, 1'b0);
    wait_drain("wrap", 30);

    // 6: misaligned redirect target
`ifdef IF_ADDR_EXC_EN
    do_redirect(32'h0000_0002);
    push_one(32'h0000_0002, 32'h0, 1'b1);
    wait_drain("addr_exc", 20);
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (imem_req) req_seen++;
    end
    chk("halted_no_req", 32'(req_seen), 32'd0);
    do_redirect(32'h0000_0000);
    push_seq(32'h0000_0000, 3);
    wait_drain("exc_resume", 30);
`else
    req_seen = 0;
    do_redirect(32'h0000_0002);
    push_one(32'h0000_0002, 32'h0000_0002, 1'b0);
    push_one(32'h0000_0006, 32'h0000_0006, 1'b0);
    push_one(32'h0000_000A, 32'h0000_000A, 1'b0);
    wait_drain("misaligned_as_is", 30);
    chk("misaligned_req_issued", 32'(req_seen), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
